// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED fader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_fader_pkg;

    // Brightness ramp states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        RISING    = 2'd1,
        IDLE_HIGH = 2'd2,
        FALLING   = 2'd3
    } fade_state_t;

    // Clock cycles per one-level brightness step, so that a full 0..MAX ramp
    // takes roughly fade_ms. Floor division, never below one cycle.
    function automatic int unsigned calc_step(input int unsigned clk_freq_hz,
                                              input int unsigned fade_ms,
                                              input int unsigned pwm_bits);
        longint unsigned max_lvl;
        longint unsigned cycles;
        max_lvl = (longint'(1) << pwm_bits) - 1;
        cycles  = (longint'(clk_freq_hz / 1000) * longint'(fade_ms)) / max_lvl;
        if (cycles < 1) begin
            return 1;
        end
        return int'(cycles);
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM generator: free-running counter 0..MAX-1, duty sampled at each period start.
// Latency: led is registered, one cycle after the counter value it reflects.
// Backpressure: none; en=0 only gates led low, the counter keeps running.
//
// Ports: clk, rst (async, active-high), en (led gate), duty (brightness level,
// taken at counter==0), led (registered PWM output).
module led_pwm #(
    parameter int unsigned pwm_bits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [pwm_bits-1:0] duty,
    output logic                led
);

    localparam logic [pwm_bits-1:0] MAX_LVL  = '1;
    localparam logic [pwm_bits-1:0] CNT_LAST = MAX_LVL - 1'b1;

    logic [pwm_bits-1:0] cnt;
    logic [pwm_bits-1:0] duty_q;
    logic [pwm_bits-1:0] duty_eff;

    // At the period boundary the freshly latched duty must already govern
    // the first cycle of the new period, so bypass the latch there.
    assign duty_eff = (cnt == '0) ? duty : duty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            duty_q <= '0;
            led    <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
                duty_q <= duty;
            end
            led <= en && (cnt < duty_eff);
        end
    end

endmodule

// File: rtl/led_fader.sv
// Breathing LED: ramps brightness up while q_in is high, down while low.
// Latency: q_in registered, state reacts one cycle later; level steps every STEP cycles.
// Backpressure: none; en=0 freezes ramp and forces led low, PWM counter keeps running.
//
// Ports: clk, rst (async, active-high), en, q_in (square wave from blinky),
// led (registered PWM drive), level (current brightness), busy (ramp active).
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 100_000_000,
    parameter int unsigned fade_ms     = 250,
    parameter int unsigned pwm_bits    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                q_in,
    output logic                led,
    output logic [pwm_bits-1:0] level,
    output logic                busy
);

    localparam int unsigned STEP = calc_step(clk_freq_hz, fade_ms, pwm_bits);
    localparam int unsigned PW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP - 1);
    localparam logic [pwm_bits-1:0] MAX_LVL    = '1;

    fade_state_t         state, state_nxt;
    logic [pwm_bits-1:0] level_nxt;
    logic [PW-1:0]       presc, presc_nxt;
    logic                q_reg;
    logic                tick;

    assign tick = (presc == PRESC_LAST);
    assign busy = (state == RISING) || (state == FALLING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_LOW;
            level <= '0;
            presc <= '0;
            q_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            presc <= presc_nxt;
            q_reg <= q_in;
        end
    end

    // A direction reversal takes priority over a coincident tick: the level
    // is kept and the prescaler restarts for the new direction.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        presc_nxt = presc;
        if (en) begin
            case (state)
                IDLE_LOW: begin
                    if (q_reg) begin
                        state_nxt = RISING;
                        presc_nxt = '0;
                    end
                end
                RISING: begin
                    if (!q_reg) begin
                        state_nxt = FALLING;
                        presc_nxt = '0;
                    end else if (level == MAX_LVL) begin
                        // reversed back while already at full brightness
                        state_nxt = IDLE_HIGH;
                    end else if (tick) begin
                        level_nxt = level + 1'b1;
                        presc_nxt = '0;
                        if (level == MAX_LVL - 1'b1) begin
                            state_nxt = IDLE_HIGH;
                        end
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!q_reg) begin
                        state_nxt = FALLING;
                        presc_nxt = '0;
                    end
                end
                FALLING: begin
                    if (q_reg) begin
                        state_nxt = RISING;
                        presc_nxt = '0;
                    end else if (level == '0) begin
                        state_nxt = IDLE_LOW;
                    end else if (tick) begin
                        level_nxt = level - 1'b1;
                        presc_nxt = '0;
                        if (level == {{(pwm_bits-1){1'b0}}, 1'b1}) begin
                            state_nxt = IDLE_LOW;
                        end
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                default: state_nxt = IDLE_LOW;
            endcase
        end
    end

    led_pwm #(
        .pwm_bits(pwm_bits)
    ) u_pwm (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .duty(level),
        .led (led)
    );

endmodule
